// File: rtl/prog_ctr_fetch_if.sv
// Fetch-stage bundle between the PC/fetch sequencer and its control sources.
// Carries the start address, branch/halt controls, LUT write port and PC outputs.
interface prog_ctr_fetch_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
);
  logic [PC_W-1:0]   start_addr_i;
  logic              stall_i;
  logic              branch_i;
  logic              rel_en_i;
  logic [7:0]        offset_i;
  logic [LUT_AW-1:0] target_idx_i;
  logic              halt_i;
  logic              lut_we_i;
  logic [LUT_AW-1:0] lut_waddr_i;
  logic [PC_W-1:0]   lut_wdata_i;
  logic [PC_W-1:0]   pc_o;
  logic              done;
  logic [15:0]       cycles_o;

  modport master (
    output start_addr_i, stall_i, branch_i, rel_en_i,
    output offset_i, target_idx_i, halt_i,
    output lut_we_i, lut_waddr_i, lut_wdata_i,
    input  pc_o, done, cycles_o
  );

  modport slave (
    input  start_addr_i, stall_i, branch_i, rel_en_i,
    input  offset_i, target_idx_i, halt_i,
    input  lut_we_i, lut_waddr_i, lut_wdata_i,
    output pc_o, done, cycles_o
  );
endinterface

// File: rtl/prog_ctr_fetch.sv
// Program counter / fetch sequencer with relative and LUT-based absolute branches.
// Optional run-cycle counter built only when CYCLE_COUNT_EN is defined.
module prog_ctr_fetch #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int LUT_AW    = 4
) (
  input logic            clk,
  input logic            reset,
  prog_ctr_fetch_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;

  state_t          state_q;
  state_t          state_n;
  logic            fresh_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_cur;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] rel_tgt;
  logic [PC_W-1:0] lut [LUT_DEPTH];

  // Until the first edge after reset the PC is the live start address,
  // so start_addr_i must stay stable through that first cycle.
  assign pc_cur  = fresh_q ? bus.start_addr_i : pc_q;
  assign rel_tgt = pc_cur + PC_W'($signed(bus.offset_i));

  assign bus.pc_o = pc_cur;
  assign bus.done = (state_q == HALTED);

  always_comb begin
    state_n = state_q;
    pc_n    = pc_cur;
    unique case (state_q)
      RUN: begin
        if (bus.stall_i) begin
          pc_n = pc_cur;
        end else if (bus.halt_i) begin
          state_n = HALTED;
        end else if (bus.branch_i) begin
          pc_n = bus.rel_en_i ? rel_tgt
                              : lut[bus.target_idx_i];
        end else begin
          pc_n = pc_cur + PC_W'(1);
        end
      end
      HALTED: begin
        pc_n = pc_cur;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fresh_q <= 1'b1;
      pc_q    <= '0;
    end else begin
      state_q <= state_n;
      fresh_q <= 1'b0;
      pc_q    <= pc_n;
    end
  end

  // Not reset: branch targets survive across program runs.
  always_ff @(posedge clk) begin
    if (bus.lut_we_i)
      lut[bus.lut_waddr_i] <= bus.lut_wdata_i;
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (state_q == RUN && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign bus.cycles_o = cyc_q;
`else
  assign bus.cycles_o = 16'h0000;
`endif
endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Directed self-checking bench for prog_ctr_fetch.
// Counter expectations follow whether CYCLE_COUNT_EN is defined.
module tb_prog_ctr_fetch;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

`ifdef CYCLE_COUNT_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  prog_ctr_fetch_if #(.PC_W(10), .LUT_AW(4)) bus ();

  prog_ctr_fetch #(
    .PC_W(10), .LUT_DEPTH(16), .LUT_AW(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.stall_i      = 1'b0;
    bus.branch_i     = 1'b0;
    bus.rel_en_i     = 1'b0;
    bus.offset_i     = 8'h00;
    bus.target_idx_i = 4'h0;
    bus.halt_i       = 1'b0;
    bus.lut_we_i     = 1'b0;
    bus.lut_waddr_i  = 4'h0;
    bus.lut_wdata_i  = 10'h000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [9:0] addr);
    step();
    bus.start_addr_i = addr;
    reset = 1'b1;
    #20;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_addr_i = 10'h040;
    reset = 1'b1;
    #2;
    checks++;
    if (bus.pc_o !== 10'h040 || bus.done !== 1'b0 || bus.cycles_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_state pc=%h done=%b cyc=%h want 040/0/0",
               bus.pc_o, bus.done, bus.cycles_o);
    end
    bus.start_addr_i = 10'h155;
    #1;
    checks++;
    if (bus.pc_o !== 10'h155) begin
      failures++;
      $display("FAIL reset_track pc=%h want 155", bus.pc_o);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_seq_halt();
    logic [15:0] cyc_exp;
    do_reset(10'h040);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.pc_o !== 10'h040 + 10'(i) || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL seq_step%0d pc=%h done=%b want %h/0",
                 i, bus.pc_o, bus.done, 10'h040 + 10'(i));
      end
      if (i == 5) bus.halt_i = 1'b1;
      step();
    end
    bus.halt_i = 1'b0;
    cyc_exp = CC ? 16'd6 : 16'd0;
    checks++;
    if (bus.done !== 1'b1 || bus.pc_o !== 10'h045 || bus.cycles_o !== cyc_exp) begin
      failures++;
      $display("FAIL halt_done pc=%h done=%b cyc=%0d want 045/1/%0d",
               bus.pc_o, bus.done, bus.cycles_o, cyc_exp);
    end
    bus.branch_i = 1'b1;
    bus.rel_en_i = 1'b1;
    bus.offset_i = 8'h10;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bus.done !== 1'b1 || bus.pc_o !== 10'h045 || bus.cycles_o !== cyc_exp) begin
      failures++;
      $display("FAIL halt_hold pc=%h done=%b cyc=%0d want 045/1/%0d",
               bus.pc_o, bus.done, bus.cycles_o, cyc_exp);
    end
    idle_inputs();
  endtask

  task automatic test_rel_branch();
    do_reset(10'h3FE);
    bus.branch_i = 1'b1;
    bus.rel_en_i = 1'b1;
    bus.offset_i = 8'h05;
    step();
    checks++;
    if (bus.pc_o !== 10'h003) begin
      failures++;
      $display("FAIL rel_fwd_wrap pc=%h want 003", bus.pc_o);
    end
    bus.offset_i = 8'hF8;
    step();
    checks++;
    if (bus.pc_o !== 10'h3FB) begin
      failures++;
      $display("FAIL rel_back_wrap pc=%h want 3FB", bus.pc_o);
    end
    bus.offset_i = 8'h80;
    step();
    checks++;
    if (bus.pc_o !== 10'h37B) begin
      failures++;
      $display("FAIL rel_min pc=%h want 37B", bus.pc_o);
    end
    idle_inputs();
    do_reset(10'h3FF);
    step();
    checks++;
    if (bus.pc_o !== 10'h000) begin
      failures++;
      $display("FAIL inc_wrap pc=%h want 000", bus.pc_o);
    end
  endtask

  task automatic test_abs_lut();
    do_reset(10'h010);
    bus.lut_we_i    = 1'b1;
    bus.lut_waddr_i = 4'd3;
    bus.lut_wdata_i = 10'h120;
    step();
    bus.lut_we_i     = 1'b0;
    bus.branch_i     = 1'b1;
    bus.rel_en_i     = 1'b0;
    bus.target_idx_i = 4'd3;
    step();
    checks++;
    if (bus.pc_o !== 10'h120) begin
      failures++;
      $display("FAIL abs_branch pc=%h want 120", bus.pc_o);
    end
    bus.lut_we_i    = 1'b1;
    bus.lut_wdata_i = 10'h200;
    step();
    checks++;
    if (bus.pc_o !== 10'h120) begin
      failures++;
      $display("FAIL abs_same_edge pc=%h want 120", bus.pc_o);
    end
    bus.lut_we_i = 1'b0;
    step();
    checks++;
    if (bus.pc_o !== 10'h200) begin
      failures++;
      $display("FAIL abs_new_val pc=%h want 200", bus.pc_o);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    do_reset(10'h100);
    bus.stall_i  = 1'b1;
    bus.halt_i   = 1'b1;
    bus.branch_i = 1'b1;
    bus.rel_en_i = 1'b1;
    bus.offset_i = 8'h10;
    step();
    step();
    checks++;
    if (bus.pc_o !== 10'h100 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL stall_prio pc=%h done=%b want 100/0", bus.pc_o, bus.done);
    end
    bus.stall_i = 1'b0;
    step();
    checks++;
    if (bus.pc_o !== 10'h100 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL halt_prio pc=%h done=%b want 100/1", bus.pc_o, bus.done);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset(10'h0A0);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (bus.pc_o !== 10'h0A7) begin
      failures++;
      $display("FAIL mid_run pc=%h want 0A7", bus.pc_o);
    end
    bus.start_addr_i = 10'h080;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pc_o !== 10'h080 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset pc=%h done=%b want 080/0", bus.pc_o, bus.done);
    end
    bus.lut_we_i    = 1'b1;
    bus.lut_waddr_i = 4'd5;
    bus.lut_wdata_i = 10'h155;
    #18;
    reset = 1'b0;
    bus.lut_we_i = 1'b0;
    bus.halt_i   = 1'b1;
    step();
    bus.halt_i = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.pc_o !== 10'h080) begin
      failures++;
      $display("FAIL halt2 pc=%h done=%b want 080/1", bus.pc_o, bus.done);
    end
    do_reset(10'h300);
    checks++;
    if (bus.done !== 1'b0 || bus.pc_o !== 10'h300) begin
      failures++;
      $display("FAIL reset_after_halt pc=%h done=%b want 300/0",
               bus.pc_o, bus.done);
    end
    step();
    checks++;
    if (bus.pc_o !== 10'h301) begin
      failures++;
      $display("FAIL resume pc=%h want 301", bus.pc_o);
    end
    bus.branch_i     = 1'b1;
    bus.target_idx_i = 4'd3;
    step();
    checks++;
    if (bus.pc_o !== 10'h200) begin
      failures++;
      $display("FAIL lut_keep3 pc=%h want 200", bus.pc_o);
    end
    bus.target_idx_i = 4'd5;
    step();
    checks++;
    if (bus.pc_o !== 10'h155) begin
      failures++;
      $display("FAIL lut_wr_in_reset pc=%h want 155", bus.pc_o);
    end
    idle_inputs();
  endtask

  task automatic test_counter();
    do_reset(10'h000);
    bus.stall_i = 1'b1;
    step();
    checks++;
    if (bus.cycles_o !== (CC ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL cyc_stall cyc=%0d want %0d", bus.cycles_o, CC ? 1 : 0);
    end
    bus.stall_i = 1'b0;
    for (int i = 1; i < 65534; i++) step();
    checks++;
    if (bus.cycles_o !== (CC ? 16'hFFFE : 16'h0)) begin
      failures++;
      $display("FAIL cyc_fffe cyc=%h want %h", bus.cycles_o, CC ? 16'hFFFE : 16'h0);
    end
    step();
    checks++;
    if (bus.cycles_o !== (CC ? 16'hFFFF : 16'h0)) begin
      failures++;
      $display("FAIL cyc_sat cyc=%h want %h", bus.cycles_o, CC ? 16'hFFFF : 16'h0);
    end
    for (int i = 0; i < 4465; i++) step();
    checks++;
    if (bus.cycles_o !== (CC ? 16'hFFFF : 16'h0)) begin
      failures++;
      $display("FAIL cyc_hold cyc=%h want %h", bus.cycles_o, CC ? 16'hFFFF : 16'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.start_addr_i = 10'h000;
    idle_inputs();
    test_reset();
    test_seq_halt();
    test_rel_branch();
    test_abs_lut();
    test_priority();
    test_reset_mid();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
